fifo: RTL
=========

Name: fifo

Overview:
- Circular FIFO (first-in first-out) buffer. It is the queue counterpart of the team's circular LIFO stack and uses the same width/size parameterisation.
- Valid/ready handshakes on both the write and the read side, with show-ahead read data.
- Sits between producer and consumer pipeline stages. Used for rate decoupling, where the stack is used for nested-return storage.

Parameters:
FIFO_WIDTH, 18, bit width of each stored word.
FIFO_SIZE, 4, log2 of depth; the FIFO holds 2^FIFO_SIZE words (default 16).

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  reset, asynchronous, active-high.
i_wr_valid  input  1  producer offers i_wr_data this cycle.
o_wr_ready  output  1  FIFO can accept a word; equals !o_full.
i_wr_data  input  FIFO_WIDTH  write data.
o_rd_valid  output  1  o_rd_data holds the oldest word; equals !o_empty.
i_rd_ready  input  1  consumer takes o_rd_data this cycle.
o_rd_data  output  FIFO_WIDTH  oldest stored word (show-ahead).
o_full  output  1  count == 2^FIFO_SIZE.
o_empty  output  1  count == 0.
o_count  output  FIFO_SIZE+1  number of stored words, 0..2^FIFO_SIZE.
o_overflow  output  1  one-cycle pulse: write attempted while full.
o_underflow  output  1  one-cycle pulse: read attempted while empty.

Behaviour:
- Reset (async assert, sync-to-clock release):
  - write pointer, read pointer, o_count, o_overflow and o_underflow all go to 0.
  - o_empty=1, o_full=0, o_wr_ready=1, o_rd_valid=0.
  - Memory contents are not reset. o_rd_data is don't-care while o_empty=1.
- Pointers are FIFO_SIZE+1 bits and wrap modulo 2^(FIFO_SIZE+1). The memory index is the low FIFO_SIZE bits.
  - empty when wr_ptr == rd_ptr.
  - full when the MSBs differ and the low bits are equal.
  - o_count = wr_ptr - rd_ptr, computed in FIFO_SIZE+1 bits. It is registered or derived from registered pointers, with no glitch paths into state.
- Accepted write: wr_en = i_wr_valid && !o_full. Stores i_wr_data at mem[wr_ptr] and increments wr_ptr.
- Accepted read: rd_en = i_rd_ready && !o_empty. Increments rd_ptr. o_rd_data = mem[rd_ptr], read combinationally (show-ahead).
- Latency: a word written in cycle N is visible on o_rd_data with o_rd_valid=1 in cycle N+1 when the FIFO was empty. There is no same-cycle write-to-read bypass.
- Simultaneous write and read when neither full nor empty:
  - both are accepted;
  - o_count is unchanged;
  - both pointers advance.
- Simultaneous write and read when full: only the read is accepted, and o_overflow pulses. Next cycle count = 2^FIFO_SIZE - 1.
- Simultaneous write and read when empty: only the write is accepted, and o_underflow pulses. Next cycle count = 1.
- Flags follow the handshake gating above:
  - o_overflow is registered: i_wr_valid && o_full in cycle N gives a pulse in cycle N+1.
  - o_underflow is registered: i_rd_ready && o_empty in cycle N gives a pulse in cycle N+1.
  - Rejected operations never change pointers or memory.
- Wrap-around: after 2^FIFO_SIZE write/read pairs, pointer low bits return to 0 and the MSB toggles. Ordering is preserved across the wrap.
- Reset mid-operation: all stored words are discarded immediately on the i_rst assertion edge. The first write after release lands at index 0.
- Formal properties:
  - o_count <= 2^FIFO_SIZE;
  - !(o_full && o_empty);
  - o_count == wr_ptr - rd_ptr;
  - count changes by +1, -1 or 0 per cycle, consistent with wr_en and rd_en.

Test Plan:
- Reset, then write 0x00001, 0x00002, 0x00003 on consecutive cycles with i_rd_ready=0 -> o_count=3, o_rd_data=0x00001. Then drain with i_rd_ready=1 -> reads 0x00001, 0x00002, 0x00003, then o_empty=1, o_count=0.
- Write 16 words 0..15 -> o_full=1, o_wr_ready=0. A 17th write of 0x3FFFF gives o_overflow=1 for one cycle and o_count stays 16. Draining returns 0..15, with 0x3FFFF absent.
- Empty FIFO, i_rd_ready=1 held with no writes -> o_underflow pulses each cycle, pointers stay 0. Then a single write of 0x0A5A5 -> o_rd_valid=1 next cycle with o_rd_data=0x0A5A5, popped the following cycle.
- Continuous write+read every cycle, 40 cycles, data = cycle index, after one priming write -> o_count constant at 1, output equals input delayed by one, correct across both pointer wraps (cycles 16 and 32).
- Full FIFO with simultaneous write and read -> read of the oldest word accepted, write rejected, o_overflow=1, o_count=15. Empty FIFO with simultaneous write and read -> o_underflow=1, o_count=1.
- Write 5 words, assert i_rst asynchronously mid-cycle -> o_empty=1 and o_count=0 before the next clock edge. After release, write 0x00007 -> read returns 0x00007, with no stale data.

Source files
------------

// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle for the circular FIFO.
// A word moves on a rising edge only when valid and ready are both high; valid never waits on ready.
interface fifo_if #(
    parameter int FIFO_WIDTH = 18
);
    logic                  i_wr_valid;
    logic                  o_wr_ready;
    logic [FIFO_WIDTH-1:0] i_wr_data;
    logic                  o_rd_valid;
    logic                  i_rd_ready;
    logic [FIFO_WIDTH-1:0] o_rd_data;

    modport master (
        output i_wr_valid, i_wr_data, i_rd_ready,
        input  o_wr_ready, o_rd_valid, o_rd_data
    );

    modport slave (
        input  i_wr_valid, i_wr_data, i_rd_ready,
        output o_wr_ready, o_rd_valid, o_rd_data
    );
endinterface

// File: rtl/fifo.sv
// Circular FIFO with show-ahead read data; pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter.
module fifo #(
    parameter int FIFO_WIDTH = 18,
    parameter int FIFO_SIZE  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fifo_if.slave                bus,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [FIFO_SIZE:0]   o_count,
    output logic                 o_overflow,
    output logic                 o_underflow
);
    localparam int DEPTH = 1 << FIFO_SIZE;

    logic [FIFO_WIDTH-1:0] r_mem [DEPTH];
    logic [FIFO_SIZE:0]    r_wr_ptr;
    logic [FIFO_SIZE:0]    r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_en;
    logic                  w_rd_en;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_SIZE] != r_rd_ptr[FIFO_SIZE]) &&
                     (r_wr_ptr[FIFO_SIZE-1:0] == r_rd_ptr[FIFO_SIZE-1:0]);
    assign w_wr_en = bus.i_wr_valid && !w_full;
    assign w_rd_en = bus.i_rd_ready && !w_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_overflow  <= bus.i_wr_valid && w_full;
            r_underflow <= bus.i_rd_ready && w_empty;
        end
    end

    // Storage is deliberately not reset; it is only observable through r_rd_ptr.
    always_ff @(posedge i_clk) begin
        if (w_wr_en && !i_rst) r_mem[r_wr_ptr[FIFO_SIZE-1:0]] <= bus.i_wr_data;
    end

    assign bus.o_wr_ready = !w_full;
    assign bus.o_rd_valid = !w_empty;
    assign bus.o_rd_data  = r_mem[r_rd_ptr[FIFO_SIZE-1:0]];

    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_count     = r_wr_ptr - r_rd_ptr;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
endmodule
